pc_fetch: RTL

- Program-counter and instruction-fetch stage of the OTTER multi-cycle core.
- Holds the PC and fetches one instruction at a time from instruction memory over a request/grant/response handshake.
- Presents the fetched IR to decode and holds it until execute commits.
- On commit, selects the next PC from the 2-bit PCSOURCE produced by the branch-condition logic, then starts the next fetch.

---
 rtl/pc_fetch_if.sv | 25 ++
 rtl/pc_fetch.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/grant/response channel between the fetch stage and imem.
// The fetch stage is the master; it issues the request and address, and memory answers with grant and read data.
interface pc_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/pc_fetch.sv
// OTTER multi-cycle PC and instruction-fetch stage.
// It fetches one instruction per request/grant/response handshake, holds IR until commit, then selects the next PC.
module pc_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_fetch_if.master  imem,
  input  logic [1:0]  i_pcsource,
  input  logic [31:0] i_jalr_tgt,
  input  logic [31:0] i_branch_tgt,
  input  logic [31:0] i_jal_tgt,
  input  logic        i_pc_write,
  output logic [31:0] o_ir,
  output logic        o_ir_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_instret,
  output logic        o_misalign_err
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_ir_valid;
  logic [31:0] r_instret;
  logic        r_err;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_ir_nxt;
  logic        w_ir_valid_nxt;
  logic [31:0] w_instret_nxt;
  logic        w_err_nxt;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_unused_jalr_lsb;

  assign w_pc_plus4        = r_pc + 32'd4;
  assign w_unused_jalr_lsb = i_jalr_tgt[0];

  // JALR clears bit 0 of its target; this mirrors the RISC-V rule.
  always_comb begin
    w_target = w_pc_plus4;
    case (i_pcsource)
      2'b00:   w_target = w_pc_plus4;
      2'b01:   w_target = {i_jalr_tgt[31:1], 1'b0};
      2'b10:   w_target = i_branch_tgt;
      2'b11:   w_target = i_jal_tgt;
      default: w_target = w_pc_plus4;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_ir_nxt       = r_ir;
    w_ir_valid_nxt = r_ir_valid;
    w_instret_nxt  = r_instret;
    w_err_nxt      = r_err;
    case (r_state)
      ST_FETCH: begin
        if (imem.gnt) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem.rvalid) begin
          w_ir_nxt       = imem.rdata;
          w_ir_valid_nxt = 1'b1;
          w_state_nxt    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_pc_write) begin
          w_ir_valid_nxt = 1'b0;
          w_instret_nxt  = r_instret + 32'd1;
          // A misaligned target still retires the instruction but parks the stage until reset.
          if (w_target[1:0] == 2'b00) begin
            w_pc_nxt    = w_target;
            w_state_nxt = ST_FETCH;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        w_state_nxt = ST_ERROR;
      end
      default: begin
        w_state_nxt = ST_ERROR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_FETCH;
      r_pc       <= RESET_PC;
      r_ir       <= NOP_INSTR;
      r_ir_valid <= 1'b0;
      r_instret  <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_ir       <= w_ir_nxt;
      r_ir_valid <= w_ir_valid_nxt;
      r_instret  <= w_instret_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign imem.req       = (r_state == ST_FETCH);
  assign imem.addr      = r_pc;
  assign o_ir           = r_ir;
  assign o_ir_valid     = r_ir_valid;
  assign o_pc           = r_pc;
  assign o_pc_plus4     = w_pc_plus4;
  assign o_instret      = r_instret;
  assign o_misalign_err = r_err;

endmodule
